stream_demux_n: RTL and testbench
=================================

// Module: stream_demux_n
// PURPOSE
//   Parametrised 1-to-N demultiplexer for valid/ready streams; next generation of the 1-bit gate demux.
//   Routes WIDTH-bit beats to one of CHANNELS registered output ports with per-channel backpressure.
//   Optional packet mode locks the route for a whole packet (in_last-terminated).
//   Sits between a single producer and N independent consumers.
// PARAMETERS
//   WIDTH        8   data bits per beat
//   CHANNELS     4   number of output channels (>=2)
//   PACKET_MODE  1   1: route latched on first beat, held until in_last; 0: every beat routed by in_sel
//   SEL_W        $clog2(CHANNELS)+1   in_sel width; the extra bit allows out-of-range codes
// PORTS
//   clk        in   1                 rising-edge clock
//   rst        in   1                 asynchronous, active-high reset
//   in_valid   in   1                 input beat valid
//   in_ready   out  1                 input beat accepted when in_valid & in_ready
//   in_data    in   WIDTH             input beat data
//   in_last    in   1                 final beat of packet (ignored when PACKET_MODE=0)
//   in_sel     in   SEL_W             destination channel index
//   out_valid  out  CHANNELS          per-channel output valid
//   out_ready  in   CHANNELS          per-channel consumer ready
//   out_data   out  CHANNELS*WIDTH    channel c data in bits [c*WIDTH +: WIDTH]
//   out_last   out  CHANNELS          per-channel last flag
//   drop_err   out  1                 1-cycle pulse: a beat was discarded (bad sel)
//   drop_cnt   out  16                saturating count of discarded beats
// BEHAVIOUR
//   Reset (async assert, sync-to-clk release): out_valid=0, out_data=0, out_last=0, drop_err=0,
//     drop_cnt=0, FSM=IDLE, cur_sel=0. in_ready is combinational and reads 1 after reset for any sel.
//   Effective select e: PACKET_MODE=0 or FSM=IDLE -> in_sel; FSM=BUSY -> cur_sel (in_sel ignored).
//   Valid route: e < CHANNELS. Invalid route: e >= CHANNELS.
//   in_ready = invalid route ? 1 : (~out_valid[e] | out_ready[e]). No dependency on in_valid.
//   Accept (in_valid & in_ready), valid route: next edge out_valid[e]=1, out_data[e]=in_data,
//     out_last[e]=in_last. Latency 1 cycle; 1 beat/cycle sustained when out_ready[e] held high.
//   Channel c with no load this cycle: out_valid[c] clears when out_valid[c] & out_ready[c].
//   Load and drain same cycle on same channel: new beat loaded, out_valid stays 1 (load wins).
//   Other channels unaffected: a stalled channel never blocks beats routed elsewhere.
//   out_data/out_last hold their value while out_valid=0 or out_ready=0.
//   Accept, invalid route: beat discarded; next edge drop_err=1 (else 0); drop_cnt+1, saturates 16'hFFFF.
//   FSM (PACKET_MODE=1 only):
//     IDLE -> BUSY: accepted beat with in_last=0; cur_sel <= in_sel (invalid codes latched too).
//     IDLE -> IDLE: accepted beat with in_last=1 (single-beat packet) or no accept.
//     BUSY -> IDLE: accepted beat with in_last=1. BUSY -> BUSY otherwise.
//     Packet with invalid latched sel: every beat accepted and dropped, drop_cnt counts each beat.
//   PACKET_MODE=0: no FSM state; in_last passed through to out_last only.
//   Reset mid-packet: FSM to IDLE, all buffered beats lost; next beat treated as packet start.
//   in_sel/in_data/in_last must be stable while in_valid=1 and in_ready=0 (producer rule).
// TESTING
//   T1 reset: assert rst mid-traffic -> out_valid=0, drop_cnt=0, in_ready=1 same cycle, FSM IDLE.
//   T2 PACKET_MODE=0, out_ready=4'hF, beats A5,3C,7E with sel 0,2,3 -> out_valid pulses on
//     ch0,ch2,ch3 one cycle after each accept, data matches, in_ready never drops.
//   T3 backpressure: out_ready[1]=0, two beats 11,22 to ch1 -> 11 held on ch1, in_ready=0 for
//     22; a beat 33 to ch2 meanwhile accepted and delivered; raise out_ready[1] -> 22 follows next cycle.
//   T4 PACKET_MODE=1: 3-beat packet sel=2 (last on beat 3), in_sel toggled to 0 on beats 2-3
//     -> all 3 beats on ch2, out_last[2]=1 on beat 3 only; next beat sel=0 goes to ch0.
//   T5 invalid sel: CHANNELS=4, sel=5, 2-beat packet -> in_ready=1, no out_valid, drop_err
//     pulses twice, drop_cnt=2; force drop_cnt near 16'hFFFF path -> stays at 16'hFFFF.
//   T6 simultaneous drain+load on ch3 with out_ready[3]=1, 8 back-to-back beats -> 8 outputs
//     on consecutive cycles, out_valid[3] continuously 1, no beat lost or duplicated.

Source files
------------

// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
//
// Purpose
//   1-to-N demultiplexer for valid/ready streams. Each beat is steered to one
//   of CHANNELS output ports. Every output port has its own one-entry register
//   stage, so a consumer that stalls only blocks beats bound for its own
//   channel. Beats whose destination is out of range are accepted, discarded
//   and counted. In packet mode the destination is captured on the first beat
//   of a packet and held until the beat carrying in_last.
//
// Parameters
//   WIDTH        data bits per beat
//   CHANNELS     number of output channels (>= 2)
//   PACKET_MODE  1: route locked per packet; 0: every beat routed by in_sel
//   SEL_W        in_sel width; one spare bit so out-of-range codes exist
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid & in_ready (combinational)
//   in_data    input beat data
//   in_last    final beat of a packet
//   in_sel     destination channel index
//   out_valid  per-channel output valid
//   out_ready  per-channel consumer ready
//   out_data   channel c data in bits [c*WIDTH +: WIDTH]
//   out_last   per-channel last flag
//   drop_err   one-cycle pulse after a beat was discarded
//   drop_cnt   saturating count of discarded beats
// -----------------------------------------------------------------------------
module stream_demux_n #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 4,
  parameter bit          PACKET_MODE = 1'b1,
  parameter int unsigned SEL_W       = $clog2(CHANNELS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_last,
  output logic                      drop_err,
  output logic [15:0]               drop_cnt
);

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  // Packet routing state
  state_e                          state_q;
  logic [SEL_W-1:0]                cur_sel_q;

  // Per-channel output register stage
  logic [CHANNELS-1:0]             valid_q;
  logic [CHANNELS-1:0][WIDTH-1:0]  data_q;
  logic [CHANNELS-1:0]             last_q;

  // Drop accounting
  logic                            drop_err_q;
  logic [15:0]                     drop_cnt_q;

  // Datapath decode
  logic [SEL_W-1:0]                eff_sel;
  logic                            route_ok;
  logic                            sel_ready;
  logic                            accept;
  logic [CHANNELS-1:0]             load;
  logic                            drop;

  // ---------------------------------------------------------------------------
  // Route decode. While a packet is open the latched select wins and in_sel is
  // ignored, so a producer may change in_sel freely mid-packet.
  // ---------------------------------------------------------------------------
  always_comb begin
    eff_sel = in_sel;
    if (PACKET_MODE && (state_q == StBusy)) begin
      eff_sel = cur_sel_q;
    end
    route_ok = (eff_sel < SEL_W'(CHANNELS));
  end

  // An out-of-range select matches no channel, so sel_ready stays 1 and the
  // beat is swallowed instead of stalling the producer.
  always_comb begin
    sel_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (eff_sel == SEL_W'(c)) begin
        sel_ready = ~valid_q[c] | out_ready[c];
      end
    end
  end

  assign in_ready = sel_ready;
  assign accept   = in_valid & sel_ready;
  assign drop     = accept & ~route_ok;

  always_comb begin
    load = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      load[c] = accept & route_ok & (eff_sel == SEL_W'(c));
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stages. A load in the same cycle as a drain keeps valid
  // high, giving one beat per cycle per channel. Data and last only change on
  // a load, so they hold while the consumer stalls or the slot is empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      last_q  <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (load[c]) begin
          valid_q[c] <= 1'b1;
          data_q[c]  <= in_data;
          last_q[c]  <= in_last;
        end else if (valid_q[c] && out_ready[c]) begin
          valid_q[c] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Discard accounting; the counter sticks at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_err_q <= drop;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM. Invalid selects are latched too, so every beat of a packet
  // aimed at a non-existent channel is dropped, not only the first one.
  // Without packet mode the FSM never leaves idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cur_sel_q <= '0;
    end else if (PACKET_MODE && accept) begin
      unique case (state_q)
        StIdle: begin
          if (!in_last) begin
            state_q   <= StBusy;
            cur_sel_q <= in_sel;
          end
        end
        StBusy: begin
          if (in_last) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign drop_err  = drop_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stream_demux_n.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_n
//
// Self-checking bench for stream_demux_n (WIDTH=8, CHANNELS=4, packet mode).
// A behavioural model tracks, per channel, the beat sitting in the output slot
// plus the open-packet destination and drop count; every cycle the DUT's
// in_ready and registered outputs are compared against it. Randomised traffic
// is followed by directed scenarios for reset, routing, backpressure, packet
// locking, discards/saturation and back-to-back streaming.
// -----------------------------------------------------------------------------
module tb_stream_demux_n;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           in_last;
  logic [SW-1:0]  in_sel;
  logic [C-1:0]   out_valid;
  logic [C-1:0]   out_ready;
  logic [C*W-1:0] out_data;
  logic [C-1:0]   out_last;
  logic           drop_err;
  logic [15:0]    drop_cnt;

  always #5 clk = ~clk;

  stream_demux_n #(
    .WIDTH      (W),
    .CHANNELS   (C),
    .PACKET_MODE(1'b1),
    .SEL_W      (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .drop_err (drop_err),
    .drop_cnt (drop_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: contents of each channel's slot, open packet, drops.
  bit         m_full [C];
  logic [W-1:0] m_data [C];
  bit         m_last [C];
  bit         m_locked;
  int         m_dest;
  int         m_cnt;
  bit         m_err;
  bit         last_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      m_full[c] = 1'b0;
      m_data[c] = '0;
      m_last[c] = 1'b0;
    end
    m_locked = 1'b0;
    m_dest   = 0;
    m_cnt    = 0;
    m_err    = 1'b0;
  endtask

  function automatic bit model_ready();
    int dest;
    dest = m_locked ? m_dest : int'(in_sel);
    if (dest >= C) return 1'b1;
    return !m_full[dest] || out_ready[dest];
  endfunction

  task automatic model_update();
    int dest;
    bit acc;
    dest = m_locked ? m_dest : int'(in_sel);
    acc  = in_valid && model_ready();
    for (int c = 0; c < C; c++) begin
      if (m_full[c] && out_ready[c]) m_full[c] = 1'b0;
    end
    if (acc && dest < C) begin
      m_full[dest] = 1'b1;
      m_data[dest] = in_data;
      m_last[dest] = in_last;
    end
    m_err = acc && (dest >= C);
    if (m_err && m_cnt < 65535) m_cnt++;
    if (acc) begin
      if (!m_locked && !in_last) begin
        m_locked = 1'b1;
        m_dest   = int'(in_sel);
      end else if (m_locked && in_last) begin
        m_locked = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [C-1:0]   ev;
    logic [C*W-1:0] ed;
    logic [C-1:0]   el;
    for (int c = 0; c < C; c++) begin
      ev[c]         = m_full[c];
      ed[c*W +: W]  = m_data[c];
      el[c]         = m_last[c];
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", 64'(out_data), 64'(ed));
    chk("out_last", 64'(out_last), 64'(el));
    chk("drop_err", 64'(drop_err), 64'(m_err));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
  endtask

  task automatic drive(input bit v, input int s, input int d, input bit l, input logic [C-1:0] r);
    in_valid  = v;
    in_sel    = SW'(s);
    in_data   = W'(d);
    in_last   = l;
    out_ready = r;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    last_rdy = model_ready();
    chk("in_ready", 64'(in_ready), 64'(last_rdy));
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 4'hF);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Randomised traffic, holding a stalled beat stable as a producer must.
    for (int i = 0; i < 300; i++) begin
      if (!(in_valid && !last_rdy)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = SW'($urandom_range(0, 5));
        in_data  = W'($urandom);
        in_last  = ($urandom_range(0, 2) == 0);
      end
      out_ready = C'($urandom);
      step();
    end

    // T1: reset in the middle of traffic; outputs clear immediately.
    drive(1, 1, 8'h99, 0, 4'h0);
    rst = 1'b1;
    #1;
    chk("t1_out_valid", 64'(out_valid), 64'(0));
    chk("t1_drop_cnt", 64'(drop_cnt), 64'(0));
    chk("t1_in_ready", 64'(in_ready), 64'(1));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 4'hF);
    step();

    // T2: single-beat packets behave as per-beat routing.
    drive(1, 0, 8'hA5, 1, 4'hF); step();
    chk("t2_ch0", 64'(out_data[0*W +: W]), 64'(8'hA5));
    drive(1, 2, 8'h3C, 1, 4'hF); step();
    chk("t2_ch2", 64'(out_data[2*W +: W]), 64'(8'h3C));
    drive(1, 3, 8'h7E, 1, 4'hF); step();
    chk("t2_ch3_valid", 64'(out_valid), 64'(4'b1000));
    drive(0, 0, 0, 0, 4'hF); step();

    // T3: channel 1 stalled; channel 2 still flows.
    drive(1, 1, 8'h11, 1, 4'b1101); step();
    drive(1, 1, 8'h22, 1, 4'b1101);
    #1;
    chk("t3_block", 64'(in_ready), 64'(0));
    step();
    chk("t3_hold", 64'(out_data[1*W +: W]), 64'(8'h11));
    drive(1, 2, 8'h33, 1, 4'b1101); step();
    chk("t3_ch2", 64'(out_data[2*W +: W]), 64'(8'h33));
    drive(1, 1, 8'h22, 1, 4'hF); step();
    chk("t3_follow", 64'(out_data[1*W +: W]), 64'(8'h22));
    drive(0, 0, 0, 0, 4'hF); step();

    // T4: packet locked to channel 2 despite in_sel changing.
    drive(1, 2, 8'hA1, 0, 4'hF); step();
    drive(1, 0, 8'hA2, 0, 4'hF); step();
    chk("t4_beat2", 64'(out_data[2*W +: W]), 64'(8'hA2));
    drive(1, 0, 8'hA3, 1, 4'hF); step();
    chk("t4_last", 64'(out_last[2]), 64'(1));
    drive(1, 0, 8'hB0, 1, 4'hF); step();
    chk("t4_next", 64'(out_valid), 64'(4'b0001));
    drive(0, 0, 0, 0, 4'hF); step();

    // T5: invalid select packet is swallowed and counted; then saturation.
    drive(1, 5, 8'h55, 0, 4'hF); step();
    drive(1, 0, 8'h66, 1, 4'hF); step();
    chk("t5_cnt", 64'(drop_cnt), 64'(2));
    drive(0, 0, 0, 0, 4'hF); step();
    force dut.drop_cnt_q = 16'hFFFE;
    #1;
    release dut.drop_cnt_q;
    m_cnt = 16'hFFFE;
    drive(1, 6, 8'h77, 1, 4'hF); step();
    drive(1, 7, 8'h78, 1, 4'hF); step();
    drive(1, 4, 8'h79, 1, 4'hF); step();
    chk("t5_sat", 64'(drop_cnt), 64'(16'hFFFF));
    drive(0, 0, 0, 0, 4'hF); step();

    // T6: back-to-back beats on channel 3 with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1, 3, 8'h60 + i, (i == 7), 4'hF);
      step();
      chk("t6_cont", 64'(out_valid[3]), 64'(1));
      chk("t6_data", 64'(out_data[3*W +: W]), 64'(8'h60 + i));
    end
    drive(0, 0, 0, 0, 4'hF); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
